// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
//   pctrl_state_t : states of the pipeline stall/flush sequencer
//   regbits_t     : register-index field (REG_BITS wide)
package cpu_types_pkg;

   localparam int REG_BITS = 5;

   typedef logic [REG_BITS-1:0] regbits_t;

   typedef enum logic [1:0] {
      PC_RUN   = 2'd0,
      PC_DWAIT = 2'd1,
      PC_HALT  = 2'd2
   } pctrl_state_t;

endpackage : cpu_types_pkg

// File: rtl/hazard_unit.sv
// Load-use hazard detector (purely combinational).
//   idex_memread : EX-stage instruction is a load
//   idex_dest    : destination register of the EX-stage instruction
//   ifid_rs/rt   : source registers of the ID-stage instruction
//   lduse        : ID-stage instruction needs the load result next cycle
module hazard_unit #(
   parameter int REG_W = 5
) (
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_dest,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   output logic             lduse
);

   // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign lduse = idex_memread && (idex_dest != '0) &&
                  ((idex_dest == ifid_rs) || (idex_dest == ifid_rt));

endmodule : hazard_unit

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   CLK, nRST          : clock (rising edge), asynchronous active-low reset
//   ihit, dhit         : instruction fetch / data access completed this cycle
//   exmem_dREN/dWEN    : MEM-stage instruction reads / writes data memory
//   exmem_redirect     : MEM-stage branch taken or jump resolved
//   idex_memread/dest  : EX-stage load flag and destination register
//   ifid_rs/rt         : ID-stage source registers
//   memwb_halt         : halt instruction leaving the MEM/WB latch
//   pc_en, *_en        : PC / latch load enables
//   *_flush            : latch loads a bubble (overrides its enable)
//   halt               : processor halted (sticky until reset)
//   stall_count        : saturating count of stalled (pc_en=0) cycles
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             exmem_redirect,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_dest,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_count
);

   pctrl_state_t state, next_state;
   logic         dreq;
   logic         lduse;

   assign dreq = exmem_dREN | exmem_dWEN;

   hazard_unit #(.REG_W(REG_W)) u_hazard (
      .idex_memread (idex_memread),
      .idex_dest    (idex_dest),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .lduse        (lduse)
   );

   always_comb begin
      // NOTE: every output gets a default first so no path through the
      // decision chain leaves a signal unassigned (which would infer a latch).
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      halt        = 1'b0;
      next_state  = state;

      if (!nRST) begin
         // Bubble every latch while reset is held.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else if (state == PC_HALT) begin
         halt = 1'b1;
      end else begin
         if (dreq && !dhit) begin
            // Freeze everything up to MEM; WB gets a bubble so the stalled
            // MEM instruction is not written back twice.
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            next_state  = PC_DWAIT;
         end else begin
            // Data side is satisfied (or idle); the fetch/hazard rules decide.
            next_state = PC_RUN;
            if (exmem_redirect) begin
               // Target is already known, so the PC loads without waiting for ihit.
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
               idex_en     = 1'b1;
               exmem_en    = 1'b1;
               memwb_en    = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end else if (lduse || !ihit) begin
               // Hold PC and IF/ID, drain a bubble into EX, let the rest move.
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
               idex_flush = 1'b1;
            end else begin
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
            end
         end
         // Halt wins over any other next-state choice, including leaving DWAIT.
         if (memwb_halt) next_state = PC_HALT;
      end
   end

   // NOTE: the asynchronous reset clears only the control state and counter;
   // the latches themselves are bubbled through the *_flush outputs.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= PC_RUN;
      end else begin
         // NOTE: sequential state is always updated with non-blocking assignments.
         state <= next_state;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_count <= '0;
      end else if ((state != PC_HALT) && !pc_en && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl. A driver applies one stimulus per cycle
// and pushes the reference model's expected outputs; a monitor pops and
// compares on the falling edge. A second instance with CNT_W=4 shares the
// inputs to exercise counter saturation.
module tb_pipeline_ctrl;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     nRST;
   logic     ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect;
   logic     idex_memread, memwb_halt;
   regbits_t idex_dest, ifid_rs, ifid_rt;

   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
   logic [31:0] stall_count;

   logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
   logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, halt4;
   logic [3:0]  stall_count4;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.CNT_W(32), .REG_W(5)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .exmem_redirect(exmem_redirect), .idex_memread(idex_memread),
      .idex_dest(idex_dest), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .memwb_halt(memwb_halt), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .halt(halt), .stall_count(stall_count)
   );

   pipeline_ctrl #(.CNT_W(4), .REG_W(5)) dut4 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .exmem_redirect(exmem_redirect), .idex_memread(idex_memread),
      .idex_dest(idex_dest), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .memwb_halt(memwb_halt), .pc_en(pc_en4), .ifid_en(ifid_en4),
      .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
      .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
      .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4),
      .halt(halt4), .stall_count(stall_count4)
   );

   typedef struct packed {
      bit       ih, dh, dr, dw, rd, mr;
      logic [4:0] dst, rs, rt;
      bit       mh;
   } stim_t;

   // ctl = {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, halt}
   typedef struct {
      logic [9:0]      ctl;
      longint unsigned cnt;
      string           tag;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state: halted flag and stalled-cycle tally.
   bit              m_halted = 1'b0;
   longint unsigned m_cnt    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic stim_t st(bit ih, bit dh, bit dr, bit dw, bit rd, bit mr,
                                logic [4:0] dst, logic [4:0] rs, logic [4:0] rt, bit mh);
      stim_t s;
      s = '{ih, dh, dr, dw, rd, mr, dst, rs, rt, mh};
      return s;
   endfunction

   // Drive one cycle of stimulus and record what the DUT must show this cycle.
   task automatic step(input bit rst, input stim_t s, input string tag);
      logic       pc, h;
      logic [3:0] en, fl;
      bit         lu;
      exp_t       e;
      @(posedge CLK);
      #1;
      nRST           = rst;
      ihit           = s.ih;
      dhit           = s.dh;
      exmem_dREN     = s.dr;
      exmem_dWEN     = s.dw;
      exmem_redirect = s.rd;
      idex_memread   = s.mr;
      idex_dest      = s.dst;
      ifid_rs        = s.rs;
      ifid_rt        = s.rt;
      memwb_halt     = s.mh;

      lu = s.mr && (s.dst != 0) && (s.dst == s.rs || s.dst == s.rt);
      if (!rst) begin
         m_halted = 1'b0;
         m_cnt    = 0;
         pc = 1'b0; en = 4'b0000; fl = 4'b1111; h = 1'b0;
      end else if (m_halted) begin
         pc = 1'b0; en = 4'b0000; fl = 4'b0000; h = 1'b1;
      end else begin
         h = 1'b0;
         if ((s.dr || s.dw) && !s.dh) begin
            pc = 1'b0; en = 4'b0001; fl = 4'b0001;
         end else if (s.rd) begin
            pc = 1'b1; en = 4'b1111; fl = 4'b1110;
         end else if (lu || !s.ih) begin
            pc = 1'b0; en = 4'b0111; fl = 4'b0100;
         end else begin
            pc = 1'b1; en = 4'b1111; fl = 4'b0000;
         end
      end
      e.ctl = {pc, en, fl, h};
      e.cnt = m_cnt;
      e.tag = tag;
      sbq.push_back(e);
      // State advance at the coming edge.
      if (rst && !m_halted) begin
         if (!pc) m_cnt++;
         if (s.mh) m_halted = 1'b1;
      end
   endtask

   // Monitor: one expected entry per driven cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.tag, ".ctl"},
                  {54'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, halt}, {54'd0, e.ctl});
            check({e.tag, ".ctl4"},
                  {54'd0, pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4,
                   ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, halt4}, {54'd0, e.ctl});
            check({e.tag, ".cnt"}, {32'd0, stall_count}, e.cnt);
            check({e.tag, ".cnt4"}, {60'd0, stall_count4}, (e.cnt > 15) ? 64'd15 : e.cnt);
         end
      end
   end

   stim_t idle;
   stim_t s;
   bit    pend;
   bit    pend_wr;

   initial begin
      nRST = 1'b0;
      {ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect, idex_memread, memwb_halt} = '0;
      idex_dest = '0; ifid_rs = '0; ifid_rt = '0;
      idle = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state, then release.
      step(0, idle, "reset0");
      step(0, idle, "reset1");
      step(1, idle, "run");

      // Data wait: three stalled cycles then advance.
      for (int i = 0; i < 3; i++) step(1, st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "dwait");
      step(1, st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "dhit");
      step(1, idle, "after_dwait");

      // Load-use on rt, then the same pattern with dest=0 (no hazard), then on rs.
      step(1, st(1, 0, 0, 0, 0, 1, 5, 3, 5, 0), "lduse_rt");
      step(1, st(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "lduse_r0");
      step(1, st(1, 0, 0, 0, 0, 1, 7, 7, 2, 0), "lduse_rs");
      step(1, st(1, 0, 0, 0, 0, 1, 6, 1, 2, 0), "load_nodep");
      step(1, st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "imiss");

      // Redirect during I-miss, then redirect against an unfinished data access.
      step(1, st(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "redir_imiss");
      step(1, st(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), "redir_dstall");
      step(1, st(1, 1, 0, 1, 0, 0, 0, 0, 0, 0), "store_done");

      // Reset asserted in the middle of a data wait.
      step(1, st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "pre_rst_dwait");
      step(1, st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "pre_rst_dwait");
      step(0, st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rst_mid_dwait");
      step(1, idle, "post_rst");

      // Randomized traffic: a data request is held until its dhit arrives.
      pend = 1'b0;
      pend_wr = 1'b0;
      for (int i = 0; i < 600; i++) begin
         s = st($urandom_range(3) != 0, 0, 0, 0, $urandom_range(7) == 0, $urandom_range(1) == 1,
                5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), 0);
         if (!pend && $urandom_range(3) == 0) begin
            pend    = 1'b1;
            pend_wr = $urandom_range(1) == 1;
         end
         if (pend) begin
            s.dr = !pend_wr;
            s.dw = pend_wr;
            s.dh = $urandom_range(2) == 0;
            if (s.dh) begin
               // Completed access: keep the rest of the pipe free of hazards.
               s.ih = 1'b1;
               s.rd = 1'b0;
               s.mr = 1'b0;
               pend = 1'b0;
            end
         end
         step(1, s, "rand");
      end

      // Halt: one-cycle pulse, then random inputs must not disturb anything.
      step(1, idle, "pre_halt");
      step(1, st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "halt_pulse");
      for (int i = 0; i < 12; i++) begin
         s = st($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1, 0,
                $urandom_range(1) == 1, 1, 5'd4, 5'd4, 5'd0, $urandom_range(1) == 1);
         step(1, s, "halted");
      end

      // Saturation of the 4-bit counter over a long I-miss.
      step(0, idle, "reset_sat");
      for (int i = 0; i < 20; i++) step(1, st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat");
      step(1, idle, "sat_end");

      @(negedge CLK);
      @(negedge CLK);
      check("sb_drain", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pipeline_ctrl

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives enable and bubble-insert (flush) controls for the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves instruction-cache misses, data-memory waits, load-use hazards, MEM-stage branch/jump redirects and halt. It also holds a saturating stall-cycle counter for performance readout.

Parameters:
CNT_W, 32, width of stall_count
REG_W, 5, register-index width (matches dest_in/dest_out of the pipeline latches)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch completed this cycle
dhit  input  1  data access completed this cycle
exmem_dREN  input  1  instruction in MEM stage reads data memory
exmem_dWEN  input  1  instruction in MEM stage writes data memory
exmem_redirect  input  1  branch taken or jump resolved in MEM stage
idex_memread  input  1  instruction in EX stage is a load
idex_dest  input  REG_W  destination register of the EX-stage instruction
ifid_rs  input  REG_W  rs field of the ID-stage instruction
ifid_rt  input  REG_W  rt field of the ID-stage instruction
memwb_halt  input  1  halt instruction present in MEM/WB latch output
pc_en  output  1  PC loads next value
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch captures its inputs
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  latch loads all-zero bubble; overrides en
halt  output  1  processor halted
stall_count  output  CNT_W  cycles in which pc_en=0 while not halted

Behaviour:
- Registered state: RUN, DWAIT, HALT. Outputs are combinational from state plus inputs; stall_count is registered.
- nRST=0 (asynchronous): state=RUN, stall_count=0. All *_en=0, pc_en=0, all *_flush=1, halt=0 while reset is held. Reset mid-DWAIT returns to RUN with no pending state.
- dreq = exmem_dREN | exmem_dWEN. Decisions are evaluated in priority order; the first that applies wins.
- 1. HALT state: all en=0, pc_en=0, flushes=0, halt=1. Sticky until reset.
- 2. dreq & !dhit (RUN or DWAIT): pc_en=ifid_en=idex_en=exmem_en=0. memwb_en=1 with memwb_flush=1, so a bubble goes to WB. Next state DWAIT.
- 3. DWAIT & dhit, or RUN & dreq & dhit: normal advance. Next state RUN.
- 4. exmem_redirect: pc_en=1 (loads target, ihit not required). ifid_flush=idex_flush=exmem_flush=1. memwb_en=1.
- 5. Load-use: idex_memread & idex_dest!=0 & (idex_dest==ifid_rs | idex_dest==ifid_rt). Then pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
- 6. !ihit: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
- 7. Otherwise: all en=1, flushes=0.
- memwb_halt=1 in RUN/DWAIT moves to HALT at the next edge. It takes precedence over leaving DWAIT. halt rises one cycle after memwb_halt.
- stall_count increments on each edge where state!=HALT and pc_en=0. It saturates at all-ones and does not wrap. It is frozen in HALT.
- Simultaneous dhit and ihit: both are consumed in the same cycle, with no extra stall.

Decomposition:
- cpu_types_pkg gains: typedef enum logic [1:0] {PC_RUN, PC_DWAIT, PC_HALT} pctrl_state_t. regbits_t is reused for REG_W fields.
- Sub-module hazard_unit: purely combinational load-use detection, producing one output, lduse.
- pipeline_ctrl instantiates hazard_unit and owns the FSM and counter.

Test Plan:
- Reset: assert nRST=0 mid-DWAIT with dREN=1, dhit=0 -> state=RUN, stall_count=0, all flushes=1; after release with ihit=1 -> all en=1.
- Data wait: dREN=1, dhit=0 for 3 cycles, then dhit=1 -> pc_en=0 and memwb_flush=1 for exactly 3 cycles; advance on the 4th cycle; stall_count=3.
- Load-use: idex_memread=1, idex_dest=5, ifid_rt=5, ihit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Repeat with idex_dest=0 -> no stall.
- Redirect during I-miss: exmem_redirect=1, ihit=0 -> pc_en=1, ifid/idex/exmem flush=1. With redirect and dREN=1, dhit=0 together -> the dmem stall wins.
- Halt: memwb_halt=1 for one cycle -> halt=1 from the next cycle onward. All en=0 thereafter, and stall_count is unchanged over 10 further cycles.
- Saturation: CNT_W=4, ihit=0 for 20 cycles -> stall_count holds at 15.
